// File: rtl/board_mem_arbiter_pkg.sv
// Shared board geometry and requester identifiers for the board-state RAM arbiter.
package board_pkg;
   localparam int LOG_W      = 6;
   localparam int LOG_H      = 5;
   localparam int AW         = LOG_W + LOG_H;
   localparam int BOARD_SIZE = 1 << AW;

   typedef enum logic [1:0] {
      REQ_DISP = 2'd0,
      REQ_STEP = 2'd1,
      REQ_LOAD = 2'd2
   } req_e;
endpackage

// File: rtl/board_mem_arbiter_if.sv
// Single-port board RAM bus: the arbiter drives it, the RAM macro answers one cycle later.
interface board_mem_arbiter_if #(
   parameter int AW = 11
);
   logic          en;
   logic          we;
   logic [AW-1:0] addr;
   logic          wdata;
   logic          rdata;

   modport master (output en, output we, output addr, output wdata, input rdata);
   modport slave  (input en, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/board_mem_arbiter_starve_counter.sv
// Saturating wait counter for one round-robin requester with a sticky starvation flag.
module starve_counter
   import board_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   input  logic gnt,
   output logic starve
);
   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_d, cnt_q;
   logic          starve_d, starve_q;

   always_comb begin
      cnt_d = '0;
      if (req && !gnt) begin
         cnt_d = (cnt_q == CW'(LIMIT)) ? cnt_q : cnt_q + 1'b1;
      end
      // The flag latches on the same edge the counter reaches the limit.
      starve_d = starve_q | (cnt_d == CW'(LIMIT));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         starve_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
      end
   end

   assign starve = starve_q;
endmodule

// File: rtl/board_mem_arbiter.sv
// Board RAM arbiter: DISP has fixed priority, STEP and LOAD share the remaining slots round-robin.
module board_mem_arbiter
   import board_pkg::*;
#(
   parameter int LOG_W        = board_pkg::LOG_W,
   parameter int LOG_H        = board_pkg::LOG_H,
   parameter int STARVE_LIMIT = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   disp_req,
   input  logic [LOG_W+LOG_H-1:0] disp_addr,
   input  logic                   step_req,
   input  logic                   step_we,
   input  logic [LOG_W+LOG_H-1:0] step_addr,
   input  logic                   step_wdata,
   input  logic                   load_req,
   input  logic [LOG_W+LOG_H-1:0] load_addr,
   input  logic                   load_wdata,
   output logic                   disp_gnt,
   output logic                   step_gnt,
   output logic                   load_gnt,
   output logic                   rdata,
   output logic                   disp_rvalid,
   output logic                   step_rvalid,
   output logic [1:0]             starve,
   board_mem_arbiter_if.master    mem
);
   localparam int AW = LOG_W + LOG_H;

   req_e          rr_ptr_d, rr_ptr_q;
   logic [AW-1:0] addr_d, addr_q;
   logic          wdata_d, wdata_q;
   logic          disp_rv_d, disp_rv_q;
   logic          step_rv_d, step_rv_q;
   logic          rdata_d, rdata_q;
   logic          en, we;

   // Grants are gated by rst_n so an asserted reset silences the RAM immediately.
   always_comb begin
      disp_gnt = 1'b0;
      step_gnt = 1'b0;
      load_gnt = 1'b0;
      we       = 1'b0;
      rr_ptr_d = rr_ptr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      if (rst_n) begin
         if (disp_req) begin
            disp_gnt = 1'b1;
            addr_d   = disp_addr;
         end else if (step_req && (!load_req || rr_ptr_q == REQ_STEP)) begin
            step_gnt = 1'b1;
            we       = step_we;
            addr_d   = step_addr;
            wdata_d  = step_we ? step_wdata : wdata_q;
            rr_ptr_d = REQ_LOAD;
         end else if (load_req) begin
            load_gnt = 1'b1;
            we       = 1'b1;
            addr_d   = load_addr;
            wdata_d  = load_wdata;
            rr_ptr_d = REQ_STEP;
         end
      end
      en = disp_gnt | step_gnt | load_gnt;
   end

   // Read tags follow the RAM's one-cycle latency; rdata keeps the last read between reads.
   always_comb begin
      disp_rv_d = disp_gnt;
      step_rv_d = step_gnt & ~step_we;
      rdata_d   = (disp_rv_q | step_rv_q) ? mem.rdata : rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q  <= REQ_STEP;
         addr_q    <= '0;
         wdata_q   <= 1'b0;
         disp_rv_q <= 1'b0;
         step_rv_q <= 1'b0;
         rdata_q   <= 1'b0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         disp_rv_q <= disp_rv_d;
         step_rv_q <= step_rv_d;
         rdata_q   <= rdata_d;
      end
   end

   assign mem.en      = en;
   assign mem.we      = we;
   assign mem.addr    = addr_d;
   assign mem.wdata   = wdata_d;
   assign rdata       = rdata_d;
   assign disp_rvalid = disp_rv_q;
   assign step_rvalid = step_rv_q;

   starve_counter #(.LIMIT(STARVE_LIMIT)) u_step_starve (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (step_req),
      .gnt    (step_gnt),
      .starve (starve[0])
   );

   starve_counter #(.LIMIT(STARVE_LIMIT)) u_load_starve (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (load_req),
      .gnt    (load_gnt),
      .starve (starve[1])
   );
endmodule

// File: tb/tb_board_mem_arbiter.sv
// Scoreboard bench for board_mem_arbiter: directed scenarios plus random traffic against a rule-level model.
module tb_board_mem_arbiter;
   import board_pkg::*;

   localparam int LIMIT = 4;
   localparam int AWB   = board_pkg::AW;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           disp_req = 1'b0, step_req = 1'b0, step_we = 1'b0, step_wdata = 1'b0;
   logic           load_req = 1'b0, load_wdata = 1'b0;
   logic [AWB-1:0] disp_addr = '0, step_addr = '0, load_addr = '0;
   logic           disp_gnt, step_gnt, load_gnt, rdata, disp_rvalid, step_rvalid;
   logic [1:0]     starve;

   board_mem_arbiter_if #(.AW(AWB)) mif ();

   board_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .disp_req    (disp_req),
      .disp_addr   (disp_addr),
      .step_req    (step_req),
      .step_we     (step_we),
      .step_addr   (step_addr),
      .step_wdata  (step_wdata),
      .load_req    (load_req),
      .load_addr   (load_addr),
      .load_wdata  (load_wdata),
      .disp_gnt    (disp_gnt),
      .step_gnt    (step_gnt),
      .load_gnt    (load_gnt),
      .rdata       (rdata),
      .disp_rvalid (disp_rvalid),
      .step_rvalid (step_rvalid),
      .starve      (starve),
      .mem         (mif)
   );

   always #5 clk = ~clk;

   // RAM macro stand-in: synchronous read and write.
   bit ram [BOARD_SIZE];
   always @(posedge clk) begin
      if (mif.en) begin
         if (mif.we) ram[mif.addr] <= mif.wdata;
         else        mif.rdata <= ram[mif.addr];
      end
   end

   // Reference model state (who is 0 none, 1 DISP, 2 STEP, 3 LOAD).
   bit             ref_mem [BOARD_SIZE];
   int             turn;
   int             waitc [2];
   bit [1:0]       starve_exp;
   logic [AWB-1:0] last_addr;
   bit             last_wdata;

   typedef struct { int cyc; bit is_disp; bit data; } rsp_t;
   rsp_t sb [$];
   int   cyc = 0;
   int   n_checks = 0, n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      turn       = 2;
      waitc[0]   = 0;
      waitc[1]   = 0;
      starve_exp = 2'b00;
      last_addr  = '0;
      last_wdata = 1'b0;
   endtask

   // Called at posedge+1; leaves at the next posedge+1.
   task automatic tick(input bit dr, input logic [AWB-1:0] da,
                       input bit sr, input bit swe, input logic [AWB-1:0] sa, input bit swd,
                       input bit lr, input logic [AWB-1:0] la, input bit lwd, output int who);
      logic [AWB-1:0] exp_addr;
      bit             exp_we, exp_wd;
      rsp_t           r;
      disp_req = dr; disp_addr = da;
      step_req = sr; step_we = swe; step_addr = sa; step_wdata = swd;
      load_req = lr; load_addr = la; load_wdata = lwd;
      #3;
      if (dr)            who = 1;
      else if (sr && lr) who = turn;
      else if (sr)       who = 2;
      else if (lr)       who = 3;
      else               who = 0;
      exp_addr = last_addr; exp_wd = last_wdata; exp_we = 1'b0;
      case (who)
         1: exp_addr = da;
         2: begin exp_addr = sa; exp_we = swe; if (swe) exp_wd = swd; end
         3: begin exp_addr = la; exp_we = 1'b1; exp_wd = lwd; end
         default: ;
      endcase
      chk("grant", {disp_gnt, step_gnt, load_gnt}, {who == 1, who == 2, who == 3});
      chk("mem_bus", {mif.en, mif.we, mif.addr, mif.wdata}, {who != 0, exp_we, exp_addr, exp_wd});
      chk("starve", starve, starve_exp);
      if (who == 1 || (who == 2 && !swe)) begin
         r.cyc = cyc + 1;
         r.is_disp = (who == 1);
         r.data = (who == 1) ? ref_mem[da] : ref_mem[sa];
         sb.push_back(r);
      end
      @(posedge clk);
      if (who == 2 && swe) ref_mem[sa] = swd;
      if (who == 3)        ref_mem[la] = lwd;
      last_addr  = exp_addr;
      last_wdata = exp_wd;
      if (who == 2) turn = 3;
      if (who == 3) turn = 2;
      waitc[0] = (sr && who != 2) ? ((waitc[0] < LIMIT) ? waitc[0] + 1 : LIMIT) : 0;
      waitc[1] = (lr && who != 3) ? ((waitc[1] < LIMIT) ? waitc[1] + 1 : LIMIT) : 0;
      if (waitc[0] == LIMIT) starve_exp[0] = 1'b1;
      if (waitc[1] == LIMIT) starve_exp[1] = 1'b1;
      #1;
   endtask

   task automatic idle(input int n);
      int who;
      repeat (n) tick(0, '0, 0, 0, '0, 0, 0, '0, 0, who);
   endtask

   // Asserts reset with whatever is being requested, checks outputs at once, releases after two edges.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_gnt", {disp_gnt, step_gnt, load_gnt}, 3'b000);
      chk("rst_mem", {mif.en, mif.we}, 2'b00);
      chk("rst_out", {disp_rvalid, step_rvalid, rdata, starve}, 5'b0);
      model_reset();
      disp_req = 1'b0; step_req = 1'b0; load_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: pops the scoreboard whenever a response is due and otherwise expects silence.
   initial begin
      rsp_t r;
      bit   exp_rdata;
      exp_rdata = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb.delete();
            exp_rdata = 1'b0;
            chk("rsp_in_reset", {disp_rvalid, step_rvalid, rdata}, 3'b000);
         end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
            r = sb.pop_front();
            chk("rsp", {disp_rvalid, step_rvalid, rdata}, {r.is_disp, !r.is_disp, r.data});
            exp_rdata = r.data;
         end else begin
            chk("rsp_idle", {disp_rvalid, step_rvalid, rdata}, {2'b00, exp_rdata});
         end
      end
   end

   initial begin
      int             who;
      bit             dr, sr, swe, swd, lr, lwd, s_hold, l_hold;
      logic [AWB-1:0] da, sa, la;
      model_reset();
      disp_req = 1'b1; step_req = 1'b1; load_req = 1'b1;
      do_reset();

      // Reset pulsed while a DISP read is in flight.
      tick(1, AWB'(3), 1, 0, AWB'(4), 0, 1, AWB'(5), 1, who);
      do_reset();
      idle(2);

      // DISP read of a cell holding 1.
      tick(0, '0, 0, 0, '0, 0, 1, AWB'('h041), 1, who);
      tick(1, AWB'('h041), 0, 0, '0, 0, 0, '0, 0, who);
      idle(2);

      // Three-way contention: DISP wins every cycle.
      do_reset();
      repeat (3) tick(1, AWB'(7), 1, 0, AWB'(8), 0, 1, AWB'(9), 1, who);
      chk("step_wait_cnt", dut.u_step_starve.cnt_q, 3);
      chk("load_wait_cnt", dut.u_load_starve.cnt_q, 3);
      idle(1);

      // Round robin between a STEP reader and a LOAD writer.
      do_reset();
      repeat (4) tick(0, '0, 1, 0, AWB'(8), 0, 1, AWB'(9), 1, who);
      idle(2);

      // LOAD starved behind DISP; flag stays after LOAD is served.
      do_reset();
      repeat (5) tick(1, AWB'(1), 0, 0, '0, 0, 1, AWB'(2), 0, who);
      tick(0, '0, 0, 0, '0, 0, 1, AWB'(2), 0, who);
      idle(2);
      chk("starve_sticky", starve, 2'b10);

      // Write then read at the top cell; cell 0 is untouched.
      tick(0, '0, 0, 0, '0, 0, 1, AWB'('h7FF), 1, who);
      tick(0, '0, 1, 0, AWB'('h7FF), 0, 0, '0, 0, who);
      tick(0, '0, 1, 0, AWB'(0), 0, 0, '0, 0, who);
      idle(2);

      // Random traffic; STEP/LOAD keep their request until granted.
      do_reset();
      s_hold = 0; l_hold = 0;
      sr = 0; swe = 0; swd = 0; sa = '0; lr = 0; lwd = 0; la = '0;
      repeat (400) begin
         dr = ($urandom_range(0, 9) < 3);
         da = ($urandom_range(0, 7) == 0) ? AWB'($urandom) : AWB'($urandom_range(0, 15));
         if (!s_hold) begin
            sr  = $urandom_range(0, 1);
            swe = $urandom_range(0, 1);
            sa  = AWB'($urandom_range(0, 15));
            swd = $urandom_range(0, 1);
         end
         if (!l_hold) begin
            lr  = ($urandom_range(0, 2) == 0);
            la  = AWB'($urandom_range(0, 15));
            lwd = $urandom_range(0, 1);
         end
         tick(dr, da, sr, swe, sa, swd, lr, la, lwd, who);
         s_hold = sr && (who != 2);
         l_hold = lr && (who != 3);
      end
      idle(3);
      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
